// File: rtl/line_mem_fetcher.sv
// line_mem_fetcher: read-side master for the single-port line memory.
// Issues sequential same-cycle reads over a word range, buffers the words in
// a small FIFO and streams them out over valid/ready with last marking and a
// one-cycle done pulse.
// Optional macro LINE_FETCH_WRAP_EN: address counter wraps modulo MEM_DEPTH
// (start address is reduced modulo MEM_DEPTH when latched).
module line_mem_fetcher #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int BUF_DEPTH  = 2,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_err,
  output logic                  mem_re,
  output logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_data_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0]  BUF_FULL    = (PW+1)'(BUF_DEPTH);
  localparam logic [31:0]  MEM_DEPTH_W = 32'(MEM_DEPTH);

  // Catch unusable configurations at elaboration time.
  if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) || (MEM_DEPTH < 2)) begin : g_bad_param
    $error("line_mem_fetcher: BUF_DEPTH must be a power of two >= 2 and MEM_DEPTH >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  state_t               r_state;
  logic [31:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_rem;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_err;

  ent_t                 r_buf [BUF_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW:0]          r_cnt;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_abort;
  ent_t                 w_head;
  ent_t                 w_push_ent;
  logic [31:0]          w_addr_nxt;
  logic [31:0]          w_start_addr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == BUF_FULL);
  assign w_head  = r_buf[r_rd_ptr];
  assign w_pop   = !w_empty && out_ready;
  // Abort only means something once a transfer is in flight.
  assign w_abort = abort && (r_state != S_IDLE);

  // A full buffer that pops this cycle frees a slot for the word read now.
  assign mem_re   = (r_state == S_FETCH) && (!w_full || w_pop);
  assign mem_addr = mem_re ? r_addr : 32'd0;
  assign w_push   = mem_re;

  // A failed read still occupies a slot (as zero) so stream length == length.
  assign w_push_ent.data = mem_rd_data_vld ? mem_rd_data : '0;
  assign w_push_ent.last = (r_rem == LEN_WIDTH'(1));

`ifdef LINE_FETCH_WRAP_EN
  assign w_addr_nxt   = (r_addr == MEM_DEPTH_W - 32'd1) ? 32'd0 : r_addr + 32'd1;
  assign w_start_addr = start_addr % MEM_DEPTH_W;
`else
  assign w_addr_nxt   = r_addr + 32'd1;
  assign w_start_addr = start_addr;
`endif

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head.data;
  assign out_last  = !w_empty && w_head.last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_err    = r_rd_err;

  // Buffer pointers and occupancy; abort flushes ahead of any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Buffer storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push && !w_abort) r_buf[r_wr_ptr] <= w_push_ent;
  end

  // Control FSM with registered busy/done/rd_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= w_start_addr;
            r_rem    <= length;
            r_rd_err <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (length == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (mem_re) begin
            if (!mem_rd_data_vld) r_rd_err <= 1'b1;
            r_addr <= w_addr_nxt;
            r_rem  <= r_rem - LEN_WIDTH'(1);
            if (r_rem == LEN_WIDTH'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_pop && w_head.last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!abort) r_done <= 1'b1;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_fetcher.sv
// Scoreboard bench for line_mem_fetcher: stimulus pushes expected read
// addresses and stream beats into queues; a negedge monitor pops and compares.
module tb_line_mem_fetcher;

  localparam int DW = 64;
  localparam int LW = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   start_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy, done, rd_err, mem_re;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_data_vld;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic          err_en;
  logic [31:0]   err_addr;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  logic [31:0] exp_addr [$];
  beat_t       exp_beat [$];

  line_mem_fetcher #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .BUF_DEPTH(2), .MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .rd_err(rd_err), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_data_vld(mem_rd_data_vld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Memory model: word[i] = i + 0x100, optional failing address.
  assign mem_rd_data     = 64'(mem_addr) + 64'h100;
  assign mem_rd_data_vld = !(err_en && (mem_addr == err_addr));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on every read and every stream handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mem_re) begin
        rd_cnt++;
        if (exp_addr.size() == 0) chk("unexpected_read", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_beat.size() == 0) chk("unexpected_beat", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
        else begin
          beat_t b;
          b = exp_beat.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_last", {63'd0, out_last}, {63'd0, b.l});
        end
      end
    end
  end

  task automatic push_xfer(input logic [31:0] addr, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      beat_t b;
`ifdef LINE_FETCH_WRAP_EN
      a = (addr + 32'(i)) % 32'd1024;
`else
      a = addr + 32'(i);
`endif
      exp_addr.push_back(a);
      b.d = (err_en && a == err_addr) ? 64'd0 : 64'(a) + 64'h100;
      b.l = (i == len - 1);
      exp_beat.push_back(b);
    end
  endtask

  // Start is sampled on the posedge inside; returns just after that edge.
  task automatic start_cmd(input logic [31:0] addr, input int len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; length = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({nm, "_busy_low"}, {63'd0, busy}, 64'd0);
    chk({nm, "_addr_q_empty"}, 64'(exp_addr.size()), 64'd0);
    chk({nm, "_beat_q_empty"}, 64'(exp_beat.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    out_ready = 1'b0; err_en = 1'b0; err_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd_err", {63'd0, rd_err}, 64'd0);
    chk("rst_mem_re", {63'd0, mem_re}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic stream: reads 4,5,6 back to back.
    out_ready = 1'b1;
    push_xfer(32'd4, 3);
    start_cmd(32'd4, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("basic_consec_re", {63'd0, mem_re}, 64'd1);
    end
    wait_done("basic");

    // Backpressure: stall 5 cycles after first valid.
    out_ready = 1'b0;
    push_xfer(32'd4, 3);
    rd_cnt = 0;
    start_cmd(32'd4, 3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data_stable", out_data, 64'h104);
      @(negedge clk);
    end
    chk("bp_mem_re_stopped", {63'd0, mem_re}, 64'd0);
    chk("bp_reads_while_full", 64'(rd_cnt), 64'd2);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("bp");

    // Read error on the 2nd read (address 5).
    err_en = 1'b1; err_addr = 32'd5;
    push_xfer(32'd4, 3);
    start_cmd(32'd4, 3);
    @(negedge clk);
    chk("rderr_before", {63'd0, rd_err}, 64'd0);
    wait_done("rderr");
    chk("rderr_sticky", {63'd0, rd_err}, 64'd1);
    err_en = 1'b0;

    // Zero length: done on the second edge after start, no reads/beats.
    start_cmd(32'd7, 0);
    @(negedge clk);
    chk("zl_busy", {63'd0, busy}, 64'd1);
    chk("zl_done_early", {63'd0, done}, 64'd0);
    chk("zl_rd_err_cleared", {63'd0, rd_err}, 64'd0);
    @(negedge clk);
    chk("zl_done", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("zl_done_pulse", {63'd0, done}, 64'd0);

    // Abort after 2 of 8 reads (buffer full, ready low), then restart.
    out_ready = 1'b0;
    exp_addr.push_back(32'd10);
    exp_addr.push_back(32'd11);
    rd_cnt = 0;
    begin
      int d0;
      d0 = done_cnt;
      start_cmd(32'd10, 8);
      @(posedge clk);
      @(posedge clk); #1 abort = 1'b1;
      chk("ab_busy_before", {63'd0, busy}, 64'd1);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("ab_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ab_busy", {63'd0, busy}, 64'd0);
      repeat (5) @(negedge clk);
      chk("ab_no_done", 64'(done_cnt), 64'(d0));
      chk("ab_reads", 64'(rd_cnt), 64'd2);
    end
    out_ready = 1'b1;
    push_xfer(32'd0, 1);
    start_cmd(32'd0, 1);
    wait_done("restart");

`ifdef LINE_FETCH_WRAP_EN
    // Wrap: 1022,1023,0,1.
    push_xfer(32'd1022, 4);
    start_cmd(32'd1022, 4);
    wait_done("wrap");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_mem_fetcher.md
Name: line_mem_fetcher

Overview:
- Read-side master for the single-port line memory.
- On a start command, issues sequential combinational reads (mem_re/mem_addr) over a word range and pushes each word into a small output buffer.
- Buffer drains to a downstream consumer over a valid/ready stream, with last-word marking and a completion pulse.
- Lets the execution pipeline consume memory contents without driving the memory address directly.

Parameters:
- DATA_WIDTH, 64, width of one memory word and of the output stream.
- LEN_WIDTH, 16, width of the transfer length (in words).
- BUF_DEPTH, 2, output buffer entries (power of two, >=2).
- MEM_DEPTH, 1024, memory depth in words; used only when the wrap feature is enabled.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command strobe; accepted only in IDLE.
- start_addr  input  32  first word address.
- length  input  LEN_WIDTH  number of words to fetch.
- abort  input  1  cancel current transfer.
- busy  output  1  high from accepted start until done or abort.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- rd_err  output  1  sticky; set when a read returns mem_rd_data_vld=0; cleared by the next accepted start.
- mem_re  output  1  memory read enable.
- mem_addr  output  32  memory word address.
- mem_rd_data  input  DATA_WIDTH  same-cycle read data.
- mem_rd_data_vld  input  1  same-cycle read valid.
- out_data  output  DATA_WIDTH  stream data (buffer head).
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_last  output  1  high with the final word of the transfer.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE and the buffer is emptied.
  - Outputs: busy=0, done=0, rd_err=0, mem_re=0, mem_addr=0, out_valid=0, out_last=0, out_data=0.
- Reset mid-transfer discards everything; no done is generated.
- States:
  - IDLE: waits for start.
  - FETCH: issues reads.
  - DRAIN: all reads issued; waits for the buffer to empty.
  - DONE: single cycle; done=1, then IDLE.
- IDLE + start:
  - Latch start_addr into the address counter and length into the remaining-issue counter; clear rd_err; busy=1 from the next cycle.
  - length==0: go directly to DONE (done pulses on the second cycle after start); no reads, no stream beats.
  - length!=0: go to FETCH.
- FETCH:
  - mem_re = 1 when (buffer count < BUF_DEPTH) or (out_valid && out_ready this cycle). Combinational, so a full buffer popping this cycle still issues a read.
  - mem_addr = address counter when mem_re=1, else 0.
  - Each issuing cycle writes mem_rd_data into the buffer tail.
  - The tail entry's last flag is set when remaining==1.
  - Address counter increments by 1; remaining decrements by 1.
  - At remaining==1 with an issue, go to DRAIN.
  - Throughput is 1 word/cycle while out_ready is held high.
- Read error: mem_re=1 with mem_rd_data_vld=0 sets rd_err. The word (zero) is still buffered, so stream length always equals length.
- DRAIN: no reads. When the entry with last=1 is popped, go to DONE.
- Stream rules:
  - out_valid = buffer non-empty; out_data and out_last come from the head entry.
  - Once out_valid=1, out_data and out_last are held stable until out_ready.
  - A push and a pop in the same cycle leave count unchanged.
- Start while busy is ignored.
- Abort (any non-IDLE state):
  - Next cycle: buffer flushed, out_valid=0, busy=0, state IDLE, no done.
  - Abort has priority over a simultaneous pop or push.
  - Abort in IDLE has no effect.
- Address arithmetic: 32-bit unsigned increment, wrapping 0xFFFFFFFF→0 (see feature).

Optional Feature:
- Macro: LINE_FETCH_WRAP_EN.
- Defined: the address counter wraps modulo MEM_DEPTH. After MEM_DEPTH-1 the next address is 0; a start_addr >= MEM_DEPTH is reduced modulo MEM_DEPTH at latch time.
- Undefined: plain 32-bit increment; MEM_DEPTH is unused.

Test Plan:
- Basic stream: memory preloaded with word[i]=i+0x100; start_addr=4, length=3, out_ready=1. Expect mem_addr 4,5,6 on consecutive cycles; out_data 0x104,0x105,0x106 with out_last only on 0x106; one done pulse; busy then low.
- Backpressure: same transfer, out_ready=0 for 5 cycles after the first valid. Expect mem_re stops once the buffer holds BUF_DEPTH=2 words; out_data stays 0x104 stable; all 3 words are delivered in order with no duplicates after ready rises.
- Zero length: start with length=0. Expect no mem_re, no out_valid, done pulses exactly once 2 cycles after start.
- Abort and restart: abort after 2 of 8 words are issued. Expect out_valid=0 and busy=0 the next cycle, no done. A new start (addr=0, length=1) then delivers word 0x100 with out_last=1.
- Read error: force mem_rd_data_vld=0 on the 2nd read of length=3. Expect rd_err=1 held until the next start, 3 beats still delivered, done pulses.
- Wrap (LINE_FETCH_WRAP_EN, MEM_DEPTH=1024): start_addr=1022, length=4. Expect mem_addr 1022,1023,0,1.
